alu_responder: RTL and testbench



---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_core.sv | 47 ++++
 rtl/alu_responder.sv | 147 ++++++++++++++
 tb/tb_alu_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU responder: opcodes, response flags, FSM states.
package alu_pkg;

   // Opcode encoding on req_op; 3'b110 and 3'b111 are illegal.
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;

   // Status bits stored alongside each result in the response FIFO.
   typedef struct packed {
      logic zero;
      logic carry;
      logic err;
   } rsp_flags_t;

   localparam int unsigned FLAGS_W = $bits(rsp_flags_t);

   // FIFO entry is {y, flags}; width depends on the data width.
   function automatic int unsigned entry_w(input int unsigned width);
      return width + FLAGS_W;
   endfunction

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: AND/OR/ADD/SUB/SLT; anything else flags err.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_y,
   output logic             o_zero,
   output logic             o_carry,
   output logic             o_err
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;
   logic           w_slt;

   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};
   assign w_slt  = $signed(i_a) < $signed(i_b);

   // Decode the opcode; MUL is sequenced by the caller and lands in the error arm here.
   always_comb begin
      o_y     = '0;
      o_carry = 1'b0;
      o_err   = 1'b0;
      case (i_op)
         OP_AND: o_y = i_a & i_b;
         OP_OR:  o_y = i_a | i_b;
         OP_ADD: begin
            o_y     = w_sum[WIDTH-1:0];
            o_carry = w_sum[WIDTH];
         end
         OP_SUB: begin
            o_y     = w_diff[WIDTH-1:0];
            o_carry = ~w_diff[WIDTH];  // no borrow means A >= B unsigned
         end
         OP_SLT: o_y = {{(WIDTH-1){1'b0}}, w_slt};
         default: o_err = 1'b1;
      endcase
   end

   assign o_zero = (o_y == '0);

endmodule

// File: rtl/alu_responder.sv
// Handshaked ALU responder: one-cycle ops via alu_core, 32-step shift-add MUL,
// results queued in a 2-entry response FIFO.
module alu_responder
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_y,
   output logic             rsp_zero,
   output logic             rsp_carry,
   output logic             rsp_err,
   output logic             busy
);

   localparam int unsigned EW    = entry_w(WIDTH);
   localparam int unsigned CW    = $clog2(WIDTH);
   localparam logic [1:0]  DEPTH = 2'(FIFO_DEPTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   state_t            r_state;
   logic [WIDTH-1:0]  r_a_sh;
   logic [WIDTH-1:0]  r_b_sh;
   logic [WIDTH-1:0]  r_acc;
   logic [CW-1:0]     r_cnt;

   logic [EW-1:0]     r_mem [2];
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_count;

   logic [WIDTH-1:0]  w_core_y;
   logic              w_core_zero;
   logic              w_core_carry;
   logic              w_core_err;
   logic              w_accept;
   logic              w_mul_done;
   logic [WIDTH-1:0]  w_acc_next;
   logic              w_push;
   logic              w_pop;
   logic [EW-1:0]     w_push_data;
   logic [EW-1:0]     w_head;
   rsp_flags_t        w_head_flags;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_op    (req_op),
      .i_a     (req_a),
      .i_b     (req_b),
      .o_y     (w_core_y),
      .o_zero  (w_core_zero),
      .o_carry (w_core_carry),
      .o_err   (w_core_err)
   );

   assign req_ready  = (r_state == IDLE) && (r_count < DEPTH);
   assign busy       = (r_state == MUL);
   assign w_accept   = req_valid && req_ready;
   assign w_acc_next = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;
   assign w_mul_done = (r_state == MUL) && (r_cnt == LAST_STEP);
   assign w_pop      = rsp_valid && rsp_ready;

   // Select what enters the FIFO: a single-cycle result or the finished product.
   always_comb begin
      w_push      = 1'b0;
      w_push_data = '0;
      if ((r_state == IDLE) && w_accept && (req_op != OP_MUL)) begin
         w_push      = 1'b1;
         w_push_data = {w_core_y, w_core_zero, w_core_carry, w_core_err};
      end else if (w_mul_done) begin
         w_push      = 1'b1;
         w_push_data = {w_acc_next, (w_acc_next == '0), 1'b0, 1'b0};
      end
   end

   // Control FSM and shift-add multiplier datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept && (req_op == OP_MUL)) begin
                  r_a_sh  <= req_a;
                  r_b_sh  <= req_b;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= MUL;
               end
            end
            MUL: begin
               r_acc  <= w_acc_next;
               r_a_sh <= r_a_sh << 1;
               r_b_sh <= r_b_sh >> 1;
               r_cnt  <= r_cnt + 1'b1;
               if (w_mul_done) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Two-entry response FIFO; req_ready guarantees no push while full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head       = r_mem[r_rptr];
   assign w_head_flags = w_head[FLAGS_W-1:0];
   assign rsp_valid    = (r_count != 2'd0);
   assign rsp_y        = w_head[EW-1:FLAGS_W];
   assign rsp_zero     = w_head_flags.zero;
   assign rsp_carry    = w_head_flags.carry;
   assign rsp_err      = w_head_flags.err;

endmodule

// File: tb/tb_alu_responder.sv
// Directed bench for alu_responder with hand-computed expectations.
module tb_alu_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_y;
   logic        rsp_zero;
   logic        rsp_carry;
   logic        rsp_err;
   logic        busy;

   int n_vec = 0;
   int n_bad = 0;

   alu_responder #(
      .WIDTH      (32),
      .FIFO_DEPTH (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_zero  (rsp_zero),
      .rsp_carry (rsp_carry),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
   endtask

   task automatic expect_rsp(input string tag, input logic [31:0] y, input logic z,
                             input logic c, input logic e);
      check({tag, ".valid"}, rsp_valid, 1'b1);
      check({tag, ".y"}, rsp_y, y);
      check({tag, ".zero"}, rsp_zero, z);
      check({tag, ".carry"}, rsp_carry, c);
      check({tag, ".err"}, rsp_err, e);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 3'b000;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      #12;
      check("rst.req_ready", req_ready, 1'b1);
      check("rst.rsp_valid", rsp_valid, 1'b0);
      check("rst.rsp_y", rsp_y, 32'h0);
      check("rst.flags", {rsp_zero, rsp_carry, rsp_err}, 3'b000);
      check("rst.busy", busy, 1'b0);
      rst_n = 1'b1;
      tick();

      // AND, one-cycle latency
      drive(3'b000, 32'hFFFF0000, 32'h0F0F0F0F);
      tick();
      req_valid = 1'b0;
      expect_rsp("and", 32'h0F0F0000, 1'b0, 1'b0, 1'b0);

      // ADD / SUB / SLT back-to-back with rsp_ready held high
      rsp_ready = 1'b1;
      drive(3'b010, 32'hFFFFFFFF, 32'h00000001);
      tick();  // pops AND, pushes ADD
      expect_rsp("add", 32'h00000000, 1'b1, 1'b1, 1'b0);
      drive(3'b011, 32'h00000001, 32'h00000002);
      tick();  // simultaneous push and pop at count 1
      expect_rsp("sub", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      check("pushpop.req_ready", req_ready, 1'b1);
      drive(3'b100, 32'hFFFFFFFF, 32'h00000000);
      tick();
      expect_rsp("slt", 32'h00000001, 1'b0, 1'b0, 1'b0);
      req_valid = 1'b0;
      tick();
      check("drain.rsp_valid", rsp_valid, 1'b0);
      rsp_ready = 1'b0;

      // MUL, with a second request held valid throughout
      drive(3'b101, 32'h0000FFFF, 32'h00010001);
      tick();
      drive(3'b000, 32'h12345678, 32'h0000FFFF);
      for (int i = 1; i <= 31; i++) begin
         check("mul.busy", busy, 1'b1);
         check("mul.req_ready", req_ready, 1'b0);
         check("mul.rsp_valid", rsp_valid, 1'b0);
         tick();
      end
      check("mul.busy_last", busy, 1'b1);
      tick();
      check("mul.busy_done", busy, 1'b0);
      expect_rsp("mul", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      check("mul.req_ready_done", req_ready, 1'b1);
      tick();  // held AND now accepted, FIFO full
      req_valid = 1'b0;
      check("held.req_ready", req_ready, 1'b0);
      check("held.head", rsp_y, 32'hFFFFFFFF);
      rsp_ready = 1'b1;
      tick();
      expect_rsp("held_and", 32'h00005678, 1'b0, 1'b0, 1'b0);
      check("held.req_ready_after_pop", req_ready, 1'b1);
      tick();
      check("held.drained", rsp_valid, 1'b0);
      rsp_ready = 1'b0;

      // Backpressure: two accepts fill the FIFO
      drive(3'b001, 32'h0000FFFF, 32'h00FF00FF);
      tick();
      check("bp.req_ready_1", req_ready, 1'b1);
      drive(3'b000, 32'h00000000, 32'h00000000);
      tick();
      req_valid = 1'b0;
      check("bp.req_ready_full", req_ready, 1'b0);
      expect_rsp("bp_or", 32'h00FFFFFF, 1'b0, 1'b0, 1'b0);
      tick();
      check("bp.hold_y", rsp_y, 32'h00FFFFFF);
      rsp_ready = 1'b1;
      tick();
      expect_rsp("bp_and", 32'h00000000, 1'b1, 1'b0, 1'b0);
      tick();
      check("bp.drained", rsp_valid, 1'b0);

      // Illegal opcodes
      drive(3'b111, 32'hDEADBEEF, 32'h12345678);
      tick();
      expect_rsp("ill7", 32'h00000000, 1'b1, 1'b0, 1'b1);
      drive(3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF);
      tick();
      expect_rsp("ill6", 32'h00000000, 1'b1, 1'b0, 1'b1);
      req_valid = 1'b0;
      tick();
      check("ill.drained", rsp_valid, 1'b0);

      // Reset during MUL discards the operation
      drive(3'b101, 32'h00000003, 32'h00000005);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("rstmul.busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rstmul.busy", busy, 1'b0);
      check("rstmul.rsp_valid", rsp_valid, 1'b0);
      check("rstmul.req_ready", req_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) tick();
      check("rstmul.no_stale", rsp_valid, 1'b0);
      check("rstmul.idle", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
